// File: rtl/shift_ctrl.sv
// Shift-unit control FSM: sequences IDLE -> LOAD -> SHIFT -> WRITE for one shift op,
// with flush abort and an illegal-op error pulse. All outputs are registered.
module shift_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       flush,
  output logic [1:0] shamt_sel,
  output logic       src_sel,
  output logic [2:0] shift_op,
  output logic       result_we,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned OP_W   = 3;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned SOP_W  = 3;

  localparam logic [OP_W-1:0]  OP_SLL     = OP_W'(3'b000);
  localparam logic [OP_W-1:0]  OP_SRL     = OP_W'(3'b001);
  localparam logic [OP_W-1:0]  OP_SRA     = OP_W'(3'b010);
  localparam logic [OP_W-1:0]  OP_SLLV    = OP_W'(3'b011);
  localparam logic [OP_W-1:0]  OP_SRAV    = OP_W'(3'b100);
  localparam logic [OP_W-1:0]  OP_LUI     = OP_W'(3'b101);
  localparam logic [OP_W-1:0]  OP_SLLX    = OP_W'(3'b110);
  localparam logic [OP_W-1:0]  OP_ILLEGAL = OP_W'(3'b111);

  localparam logic [SOP_W-1:0] SOP_HOLD   = SOP_W'(3'b000);
  localparam logic [SOP_W-1:0] SOP_LOAD   = SOP_W'(3'b001);
  localparam logic [SOP_W-1:0] SOP_LEFT   = SOP_W'(3'b010);
  localparam logic [SOP_W-1:0] SOP_RLOG   = SOP_W'(3'b011);
  localparam logic [SOP_W-1:0] SOP_RARI   = SOP_W'(3'b100);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t           r_state;
  logic [OP_W-1:0]  r_op;

  state_t           w_state_nxt;
  logic [OP_W-1:0]  w_op_nxt;
  logic             w_err_nxt;
  logic [SEL_W-1:0] w_dec_shamt;
  logic             w_dec_src;
  logic [SOP_W-1:0] w_dec_dir;
  logic [SEL_W-1:0] w_shamt_nxt;
  logic             w_src_nxt;
  logic [SOP_W-1:0] w_sop_nxt;
  logic             w_we_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  // Next state and op latch; flush overrides everything and blocks a start in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_err_nxt   = 1'b0;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (op == OP_ILLEGAL) begin
              w_err_nxt = 1'b1;
            end else begin
              w_op_nxt    = op;
              w_state_nxt = S_LOAD;
            end
          end
        end
        S_LOAD:  w_state_nxt = S_SHIFT;
        S_SHIFT: w_state_nxt = S_WRITE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Op decode of the op that will be held in the next cycle.
  always_comb begin
    w_dec_shamt = SEL_W'(2'b00);
    w_dec_src   = 1'b0;
    w_dec_dir   = SOP_HOLD;
    case (w_op_nxt)
      OP_SLL:  w_dec_dir = SOP_LEFT;
      OP_SRL:  w_dec_dir = SOP_RLOG;
      OP_SRA:  w_dec_dir = SOP_RARI;
      OP_SLLV: begin w_dec_shamt = SEL_W'(2'b01); w_dec_dir = SOP_LEFT; end
      OP_SRAV: begin w_dec_shamt = SEL_W'(2'b01); w_dec_dir = SOP_RARI; end
      OP_LUI:  begin w_dec_shamt = SEL_W'(2'b10); w_dec_src = 1'b1; w_dec_dir = SOP_LEFT; end
      OP_SLLX: begin w_dec_shamt = SEL_W'(2'b11); w_dec_dir = SOP_LEFT; end
      default: ;
    endcase
  end

  // Moore output decode from next state and next latched op, registered below.
  always_comb begin
    w_shamt_nxt = SEL_W'(2'b00);
    w_src_nxt   = 1'b0;
    w_sop_nxt   = SOP_HOLD;
    w_we_nxt    = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (w_state_nxt)
      S_LOAD: begin
        w_shamt_nxt = w_dec_shamt;
        w_src_nxt   = w_dec_src;
        w_sop_nxt   = SOP_LOAD;
        w_busy_nxt  = 1'b1;
      end
      S_SHIFT: begin
        w_shamt_nxt = w_dec_shamt;
        w_src_nxt   = w_dec_src;
        w_sop_nxt   = w_dec_dir;
        w_busy_nxt  = 1'b1;
      end
      S_WRITE: begin
        w_shamt_nxt = w_dec_shamt;
        w_src_nxt   = w_dec_src;
        w_we_nxt    = 1'b1;
        w_busy_nxt  = 1'b1;
        w_done_nxt  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_op      <= OP_SLL;
      shamt_sel <= SEL_W'(2'b00);
      src_sel   <= 1'b0;
      shift_op  <= SOP_HOLD;
      result_we <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_op      <= w_op_nxt;
      shamt_sel <= w_shamt_nxt;
      src_sel   <= w_src_nxt;
      shift_op  <= w_sop_nxt;
      result_we <= w_we_nxt;
      busy      <= w_busy_nxt;
      done      <= w_done_nxt;
      err       <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed bench for shift_ctrl: each step advances one clock and compares the
// packed output vector {busy,done,err,result_we,src_sel,shamt_sel,shift_op}.
module tb_shift_ctrl;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [2:0] op;
  logic       flush;
  logic [1:0] shamt_sel;
  logic       src_sel;
  logic [2:0] shift_op;
  logic       result_we;
  logic       busy;
  logic       done;
  logic       err;

  int n_vec;
  int n_err;

  shift_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .flush     (flush),
    .shamt_sel (shamt_sel),
    .src_sel   (src_sel),
    .shift_op  (shift_op),
    .result_we (result_we),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] w_obs;
  assign w_obs = {busy, done, err, result_we, src_sel, shamt_sel, shift_op};

  localparam logic [9:0] M_ALL   = 10'b11_1111_1111;
  // WRITE leaves shamt_sel/src_sel unconstrained, so those bits are masked there.
  localparam logic [9:0] M_WRITE = 10'b11_1100_0111;

  function automatic logic [9:0] v(input logic b, input logic d, input logic e,
                                   input logic we, input logic src,
                                   input logic [1:0] sh, input logic [2:0] sop);
    return {b, d, e, we, src, sh, sop};
  endfunction

  task automatic chk(input string tag, input logic [9:0] exp, input logic [9:0] mask);
    n_vec++;
    assert ((w_obs & mask) === (exp & mask))
    else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, w_obs & mask, exp & mask);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] e_idle, e_write, e_err;

  initial begin
    n_vec   = 0;
    n_err   = 0;
    e_idle  = v(0, 0, 0, 0, 0, 2'b00, 3'b000);
    e_write = v(1, 1, 0, 1, 0, 2'b00, 3'b000);
    e_err   = v(0, 0, 1, 0, 0, 2'b00, 3'b000);
    start   = 1'b0;
    op      = 3'b000;
    flush   = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1 chk("reset_state", e_idle, M_ALL);
    tick();
    chk("reset_held", e_idle, M_ALL);
    reset_n = 1'b1;

    // SLL
    start = 1'b1; op = 3'b000;
    tick(); start = 1'b0;
    chk("sll_load",  v(1, 0, 0, 0, 0, 2'b00, 3'b001), M_ALL);
    tick(); chk("sll_shift", v(1, 0, 0, 0, 0, 2'b00, 3'b010), M_ALL);
    tick(); chk("sll_write", e_write, M_WRITE);
    tick(); chk("sll_idle",  e_idle, M_ALL);

    // LUI
    start = 1'b1; op = 3'b101;
    tick(); start = 1'b0;
    chk("lui_load",  v(1, 0, 0, 0, 1, 2'b10, 3'b001), M_ALL);
    tick(); chk("lui_shift", v(1, 0, 0, 0, 1, 2'b10, 3'b010), M_ALL);
    tick(); chk("lui_write", e_write, M_WRITE);
    tick(); chk("lui_idle",  e_idle, M_ALL);

    // Illegal op
    start = 1'b1; op = 3'b111;
    tick(); start = 1'b0;
    chk("ill_err",   e_err, M_ALL);
    tick(); chk("ill_clear", e_idle, M_ALL);

    // Flush in IDLE blocks a simultaneous start
    start = 1'b1; flush = 1'b1; op = 3'b000;
    tick(); start = 1'b0; flush = 1'b0;
    chk("flush_idle_block", e_idle, M_ALL);

    // SRAV flushed in SHIFT
    start = 1'b1; op = 3'b100;
    tick(); start = 1'b0;
    chk("srav_load",  v(1, 0, 0, 0, 0, 2'b01, 3'b001), M_ALL);
    tick(); chk("srav_shift", v(1, 0, 0, 0, 0, 2'b01, 3'b100), M_ALL);
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk("srav_flushed", e_idle, M_ALL);
    tick(); chk("srav_no_done", e_idle, M_ALL);

    // SRL completes normally after flush
    start = 1'b1; op = 3'b001;
    tick(); start = 1'b0;
    chk("srl_load",  v(1, 0, 0, 0, 0, 2'b00, 3'b001), M_ALL);
    tick(); chk("srl_shift", v(1, 0, 0, 0, 0, 2'b00, 3'b011), M_ALL);
    tick(); chk("srl_write", e_write, M_WRITE);
    tick(); chk("srl_idle",  e_idle, M_ALL);

    // SLLX flushed in WRITE: flush beats the WRITE->IDLE completion
    start = 1'b1; op = 3'b110;
    tick(); start = 1'b0;
    chk("sllx_load",  v(1, 0, 0, 0, 0, 2'b11, 3'b001), M_ALL);
    tick(); chk("sllx_shift", v(1, 0, 0, 0, 0, 2'b11, 3'b010), M_ALL);
    tick(); chk("sllx_write", e_write, M_WRITE);
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk("sllx_flush_write", e_idle, M_ALL);

    // Reset between edges during WRITE
    start = 1'b1; op = 3'b000;
    tick(); start = 1'b0;
    tick();
    tick(); chk("rst_pre_write", e_write, M_WRITE);
    #2 reset_n = 1'b0;
    #1 chk("rst_async_clear", e_idle, M_ALL);
    tick(); chk("rst_hold", e_idle, M_ALL);
    #1 reset_n = 1'b1;
    start = 1'b1; op = 3'b011;
    tick(); start = 1'b0;
    chk("sllv_load",  v(1, 0, 0, 0, 0, 2'b01, 3'b001), M_ALL);
    tick(); chk("sllv_shift", v(1, 0, 0, 0, 0, 2'b01, 3'b010), M_ALL);
    tick(); chk("sllv_write", e_write, M_WRITE);
    tick(); chk("sllv_idle",  e_idle, M_ALL);

    // SRA with start held and op toggling
    start = 1'b1; op = 3'b010;
    tick(); chk("sra_load",  v(1, 0, 0, 0, 0, 2'b00, 3'b001), M_ALL);
    op = 3'b111;
    tick(); chk("sra_shift", v(1, 0, 0, 0, 0, 2'b00, 3'b100), M_ALL);
    op = 3'b101;
    tick(); chk("sra_write", e_write, M_WRITE);
    op = 3'b010;
    tick(); chk("sra_idle_gap", e_idle, M_ALL);
    tick(); chk("sra_reaccept", v(1, 0, 0, 0, 0, 2'b00, 3'b001), M_ALL);
    start = 1'b0; op = 3'b000;
    tick(); chk("sra2_shift", v(1, 0, 0, 0, 0, 2'b00, 3'b100), M_ALL);
    tick(); chk("sra2_write", e_write, M_WRITE);
    tick(); chk("sra2_idle",  e_idle, M_ALL);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_ctrl.md
SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset.
REQ-002 Ports (clock and reset first):
- clk  in  1  rising-edge clock
- reset_n  in  1  async reset, active low
- start  in  1  shift request, sampled in IDLE only
- op  in  3  shift operation code (REQ-006)
- flush  in  1  synchronous abort
- shamt_sel  out  2  select for the shift-amount mux: 00 shamt field, 01 rs[4:0], 10 constant 16, 11 external amount
- src_sel  out  1  shifter data source: 0 rt register, 1 immediate
- shift_op  out  3  shift-register command: 000 hold, 001 load, 010 left, 011 right logical, 100 right arithmetic
- result_we  out  1  write enable for the shift result into the destination register
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle illegal-op pulse

Function
REQ-003 FSM states SHALL be IDLE, LOAD, SHIFT and WRITE.
REQ-004 All outputs SHALL be Moore outputs, decoded from the state register and the latched op only.
REQ-005 In IDLE, start=1 with a legal op SHALL latch op and move to LOAD on the next edge.
REQ-006 Op decode SHALL be:
- 000 SLL: shamt_sel 00, src 0, left
- 001 SRL: shamt_sel 00, src 0, right logical
- 010 SRA: shamt_sel 00, src 0, right arithmetic
- 011 SLLV: shamt_sel 01, src 0, left
- 100 SRAV: shamt_sel 01, src 0, right arithmetic
- 101 LUI: shamt_sel 10, src 1, left
- 110 SLLX: shamt_sel 11, src 0, left
- 111: illegal
REQ-007 start=1 in IDLE with op=111 SHALL pulse err for exactly the next cycle and remain in IDLE, with op not latched.
REQ-008 The LOAD state SHALL drive shift_op=001 with shamt_sel and src_sel from the latched op, then go to SHIFT.
REQ-009 The SHIFT state SHALL drive the direction code of the latched op, hold shamt_sel and src_sel, then go to WRITE.
REQ-010 The WRITE state SHALL drive shift_op=000, result_we=1 and done=1 for exactly one cycle, then go to IDLE.
REQ-011 Latency SHALL be fixed: done is high in the third cycle after the start-accept edge, and there is no back-to-back overlap.
REQ-012 start asserted in LOAD, SHIFT or WRITE SHALL be ignored, with no queuing.
REQ-013 start may be asserted in the cycle after done (IDLE), and SHALL then be accepted normally.
REQ-014 flush=1 in any non-IDLE state SHALL force IDLE on the next edge, with no result_we and no done.
REQ-015 flush has priority over all transitions, including WRITE.
REQ-016 flush in IDLE SHALL have no effect and SHALL block a simultaneous start.
REQ-017 In IDLE, shift_op SHALL be 000, shamt_sel and src_sel 0, and result_we, done and err 0.
REQ-018 A latched op SHALL be stable from LOAD through WRITE regardless of changes on op.

Reset
REQ-019 reset_n=0 SHALL immediately force IDLE, clear the latched op to 000 and drive every output to 0, independent of clk.
REQ-020 Reset asserted mid-operation (LOAD, SHIFT or WRITE) SHALL abort it, with no result_we and no done.
REQ-021 After reset_n deasserts, the first start SHALL be accepted no earlier than the first rising edge with reset_n=1.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- SLL (op 000) start at edge 0 -> edge 1 LOAD with shift_op=001, shamt_sel=00; edge 2 shift_op=010; edge 3 result_we=1, done=1; edge 4 busy=0
- LUI (op 101) -> shamt_sel=10 and src_sel=1 in LOAD and SHIFT, shift_op=010 in SHIFT, done 3 cycles after accept
- op 111 with start in IDLE -> err=1 for one cycle, busy stays 0, no shift_op activity
- SRAV accepted, flush=1 during SHIFT -> IDLE next edge, result_we and done never asserted, then a new SRL completes normally
- reset_n pulled low during WRITE, between edges -> outputs 0 immediately; after release, start with op 011 -> LOAD with shamt_sel=01
- start held high and op toggling throughout an SRA -> single completion with shift_op=100 in SHIFT, next op accepted only in the cycle after done
